digital_seq_3v3: RTL and testbench



---
 rtl/digital_seq_pkg.sv | 29 ++
 rtl/digital_seq_3v3_if.sv | 19 +
 rtl/digital_seq_timer.sv | 39 +++
 rtl/digital_seq_3v3.sv | 156 +++++++++++++++
 tb/tb_digital_seq_3v3.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/digital_seq_pkg.sv
// Purpose: shared types and limits for the 3v3 digital-domain staged enable sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the sequencer state encoding and the legal ranges for the stage count
// and the inter-stage delay width. FAULT is always encoded here; it is only
// reachable when the top is built with DIGITAL_SEQ_FAULT_EN.
package digital_seq_pkg;

    localparam logic [2:0] ST_OFF_ENC   = 3'd0;
    localparam logic [2:0] ST_UP_ENC    = 3'd1;
    localparam logic [2:0] ST_ON_ENC    = 3'd2;
    localparam logic [2:0] ST_DOWN_ENC  = 3'd3;
    localparam logic [2:0] ST_FAULT_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_OFF   = ST_OFF_ENC,
        ST_UP    = ST_UP_ENC,
        ST_ON    = ST_ON_ENC,
        ST_DOWN  = ST_DOWN_ENC,
        ST_FAULT = ST_FAULT_ENC
    } state_t;

    localparam int NSTAGE_MIN = 2;
    localparam int NSTAGE_MAX = 16;
    localparam int DLY_W_MIN  = 1;
    localparam int DLY_W_MAX  = 16;

endpackage

// File: rtl/digital_seq_3v3_if.sv
// Purpose: request/status bundle between power-management logic and the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; req is a level, ack/busy report progress.
//
// master: power-management side (drives req, dly; observes en, ack, busy).
// slave : sequencer side (observes req, dly; drives en, ack, busy).
interface digital_seq_3v3_if #(
    parameter int NSTAGE = 4,
    parameter int DLY_W  = 8
);
    logic              req;
    logic [DLY_W-1:0]  dly;
    logic [NSTAGE-1:0] en;
    logic              ack;
    logic              busy;

    modport master (output req, output dly, input en, input ack, input busy);
    modport slave  (input req, input dly, output en, output ack, output busy);
endinterface

// File: rtl/digital_seq_timer.sv
// Purpose: inter-stage gap down-counter with load, decrement and zero flag.
// Latency: load/decrement visible one clk after the controlling edge.
// Backpressure: none; load wins over decrement, decrement saturates at zero.
//
// Ports: clk, resetn (sync, active-low), load + load_val, dec, zero (cnt == 0).
module digital_seq_timer #(
    parameter int DLY_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    localparam logic [DLY_W-1:0] CNT_ONE = {{(DLY_W-1){1'b0}}, 1'b1};

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && !zero) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/digital_seq_3v3.sv
// Purpose: staged enable sequencer; ramps NSTAGE enables up in ascending order and down in descending order.
// Latency: en[k] rises 1+k*(dly+1) edges after req=1 is first seen in OFF; ack after NSTAGE*(dly+1) more gaps.
// Backpressure: req is a level; reversal mid-sequence turns around on the next edge, ack only when fully on.
//
// Ports: clk, resetn (sync, active-low), bus (digital_seq_3v3_if.slave: req, dly, en, ack, busy),
//        fault (only with DIGITAL_SEQ_FAULT_EN: forces all enables off and latches FAULT).
// Optional feature macro: DIGITAL_SEQ_FAULT_EN.
// en is always a thermometer code, so "set lowest clear bit" is a left shift in
// of a one and "clear highest set bit" is a right shift in of a zero.
module digital_seq_3v3
    import digital_seq_pkg::*;
#(
    parameter int NSTAGE = 4,
    parameter int DLY_W  = 8
) (
    input  logic clk,
    input  logic resetn,
`ifdef DIGITAL_SEQ_FAULT_EN
    input  logic fault,
`endif
    digital_seq_3v3_if.slave bus
);

    if (NSTAGE < NSTAGE_MIN || NSTAGE > NSTAGE_MAX || DLY_W < DLY_W_MIN || DLY_W > DLY_W_MAX) begin : g_bad_param
        $error("digital_seq_3v3: NSTAGE or DLY_W out of range");
    end

    state_t            state_q, state_d;
    logic [NSTAGE-1:0] en_q, en_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;

    logic [NSTAGE-1:0] en_up;
    logic [NSTAGE-1:0] en_dn;
    logic              en_full;
    logic              en_empty;

    assign en_up    = {en_q[NSTAGE-2:0], 1'b1};
    assign en_dn    = {1'b0, en_q[NSTAGE-1:1]};
    assign en_full  = &en_q;
    assign en_empty = (en_q == '0);

    digital_seq_timer #(.DLY_W(DLY_W)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (bus.dly),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_OFF;
            en_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Next state; a req reversal takes precedence over the gap counter
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF:  if (bus.req) state_d = ST_UP;
            ST_UP: begin
                if (!bus.req)                state_d = ST_DOWN;
                else if (tmr_zero && en_full) state_d = ST_ON;
            end
            ST_ON:   if (!bus.req) state_d = ST_DOWN;
            ST_DOWN: begin
                if (bus.req)                   state_d = ST_UP;
                else if (tmr_zero && en_empty) state_d = ST_OFF;
            end
`ifdef DIGITAL_SEQ_FAULT_EN
            ST_FAULT: if (!fault && !bus.req) state_d = ST_OFF;
`endif
            default: state_d = ST_OFF;
        endcase
`ifdef DIGITAL_SEQ_FAULT_EN
        if (fault) state_d = ST_FAULT;
`endif
    end

    // Enable vector and gap-timer control; each stage step reloads the gap from dly
    always_comb begin
        en_d     = en_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                if (bus.req) begin
                    en_d     = en_up;
                    tmr_load = 1'b1;
                end
            end
            ST_UP: begin
                if (!bus.req) begin
                    en_d     = en_dn;
                    tmr_load = 1'b1;
                end else if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (!en_full) begin
                    en_d     = en_up;
                    tmr_load = 1'b1;
                end
            end
            ST_ON: begin
                if (!bus.req) begin
                    en_d     = en_dn;
                    tmr_load = 1'b1;
                end
            end
            ST_DOWN: begin
                if (bus.req) begin
                    en_d     = en_up;
                    tmr_load = 1'b1;
                end else if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (!en_empty) begin
                    en_d     = en_dn;
                    tmr_load = 1'b1;
                end
            end
            default: en_d = '0;
        endcase
`ifdef DIGITAL_SEQ_FAULT_EN
        if (fault) begin
            en_d     = '0;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end
`endif
    end

    // Status flags are registered copies of the next-state decode
    always_comb begin
        ack_d  = (state_d == ST_ON);
        busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
    end

    assign bus.en   = en_q;
    assign bus.ack  = ack_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_digital_seq_3v3.sv
// Purpose: self-checking bench for digital_seq_3v3 (NSTAGE=4, DLY_W=8).
// Latency: outputs sampled 1 time unit after each rising clk.
// Backpressure: n/a.
module tb_digital_seq_3v3;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk;
    logic resetn;
    logic fault_v;

    digital_seq_3v3_if #(.NSTAGE(N), .DLY_W(DW)) bus ();

    digital_seq_3v3 #(.NSTAGE(N), .DLY_W(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
`ifdef DIGITAL_SEQ_FAULT_EN
        .fault  (fault_v),
`endif
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: number of stages on, remaining gap, direction of travel.
    int m_level;
    int m_t;
    int m_dir;
    bit m_moving;
    bit m_fault;

    function automatic void model_edge(bit rn, bit rq, int d, bit flt);
        int target;
        int want;
        if (!rn) begin
            m_level = 0; m_t = 0; m_dir = 0; m_moving = 0; m_fault = 0;
            return;
        end
        if (flt) begin
            m_fault = 1; m_level = 0; m_moving = 0;
            return;
        end
        if (m_fault) begin
            if (!rq) m_fault = 0;
            return;
        end
        target = rq ? N : 0;
        want   = rq ? 1 : -1;
        if (!m_moving) begin
            if (m_level != target) begin
                m_level += want; m_t = d; m_moving = 1; m_dir = want;
            end
        end else if (want != m_dir) begin
            m_level += want; m_t = d; m_dir = want;
        end else if (m_t > 0) begin
            m_t--;
        end else if (m_level != target) begin
            m_level += want; m_t = d;
        end else begin
            m_moving = 0;
        end
    endfunction

    function automatic logic [N-1:0] therm(int lvl);
        logic [N:0] one;
        one = 1;
        return N'((one << lvl) - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(resetn, bus.req, int'(bus.dly), fault_v);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_out(string nm, logic [N-1:0] e_en, logic e_ack, logic e_busy);
        chk({nm, ".en"},   32'(bus.en),   32'(e_en));
        chk({nm, ".ack"},  32'(bus.ack),  32'(e_ack));
        chk({nm, ".busy"}, 32'(bus.busy), 32'(e_busy));
    endtask

    task automatic wait_ack(string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (bus.ack === 1'b1) seen = 1;
        end
        chk({nm, ".ack_timeout"}, 32'(seen), 32'd1);
    endtask

    typedef struct {
        bit           rn;
        bit           rq;
        logic [DW-1:0] d;
        logic [N-1:0] e_en;
        bit           e_ack;
        bit           e_busy;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // dly=0 ramp up, hold, ramp down, then a one-stage reversal
        tbl[0]  = '{0, 0, 0, 4'b0000, 0, 0};
        tbl[1]  = '{1, 1, 0, 4'b0001, 0, 1};
        tbl[2]  = '{1, 1, 0, 4'b0011, 0, 1};
        tbl[3]  = '{1, 1, 0, 4'b0111, 0, 1};
        tbl[4]  = '{1, 1, 0, 4'b1111, 0, 1};
        tbl[5]  = '{1, 1, 0, 4'b1111, 1, 0};
        tbl[6]  = '{1, 1, 0, 4'b1111, 1, 0};
        tbl[7]  = '{1, 0, 0, 4'b0111, 0, 1};
        tbl[8]  = '{1, 0, 0, 4'b0011, 0, 1};
        tbl[9]  = '{1, 0, 0, 4'b0001, 0, 1};
        tbl[10] = '{1, 0, 0, 4'b0000, 0, 1};
        tbl[11] = '{1, 0, 0, 4'b0000, 0, 0};
        tbl[12] = '{1, 1, 0, 4'b0001, 0, 1};
        tbl[13] = '{1, 0, 0, 4'b0000, 0, 1};
        tbl[14] = '{1, 0, 0, 4'b0000, 0, 0};

        resetn  = 1'b0;
        fault_v = 1'b0;
        bus.req = 1'b0;
        bus.dly = '0;

        for (int i = 0; i < 15; i++) begin
            resetn  = tbl[i].rn;
            bus.req = tbl[i].rq;
            bus.dly = tbl[i].d;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_ack, tbl[i].e_busy);
        end

        // dly=2 ramp up: en[k] at k*3 edges after the first, ack after 12
        bus.dly = 8'd2;
        bus.req = 1'b1;
        for (int c = 0; c < 14; c++) begin
            logic [N-1:0] e;
            e = '0;
            for (int k = 0; k < N; k++) if (c >= k * 3) e[k] = 1'b1;
            step();
            chk_out($sformatf("ramp_up_c%0d", c), e, c >= 12, c < 12);
        end

        // dly=2 ramp down from ON
        bus.req = 1'b0;
        for (int c = 0; c < 14; c++) begin
            int lvl;
            lvl = 3 - c / 3;
            if (lvl < 0) lvl = 0;
            step();
            chk_out($sformatf("ramp_dn_c%0d", c), therm(lvl), 1'b0, c < 12);
        end

        // Reversal with dly=3 while counting between stage 2 and 3
        bus.dly = 8'd3;
        bus.req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) chk_out("rev_first", 4'b0001, 1'b0, 1'b1);
            if (c == 4) chk_out("rev_second", 4'b0011, 1'b0, 1'b1);
        end
        bus.req = 1'b0;
        step();
        chk_out("rev_turn", 4'b0001, 1'b0, 1'b1);
        for (int c = 7; c < 10; c++) begin
            step();
            chk_out($sformatf("rev_hold_c%0d", c), 4'b0001, 1'b0, 1'b1);
        end
        step();
        chk_out("rev_empty", 4'b0000, 1'b0, 1'b1);
        repeat (4) step();
        chk_out("rev_off", 4'b0000, 1'b0, 1'b0);

        // Reset in the middle of a ramp, then restart from stage 0
        bus.dly = 8'd1;
        bus.req = 1'b1;
        repeat (5) step();
        chk_out("rst_pre", 4'b0111, 1'b0, 1'b1);
        resetn = 1'b0;
        step();
        chk_out("rst_mid", 4'b0000, 1'b0, 1'b0);
        resetn = 1'b1;
        step();
        chk_out("rst_restart", 4'b0001, 1'b0, 1'b1);
        repeat (2) step();
        chk_out("rst_restart2", 4'b0011, 1'b0, 1'b1);
        wait_ack("rst_full");

`ifdef DIGITAL_SEQ_FAULT_EN
        // Fault while ON, latched until fault=0 and req=0 together
        fault_v = 1'b1;
        step();
        chk_out("flt_hit", 4'b0000, 1'b0, 1'b0);
        fault_v = 1'b0;
        bus.req = 1'b1;
        repeat (3) begin
            step();
            chk_out("flt_hold", 4'b0000, 1'b0, 1'b0);
        end
        bus.req = 1'b0;
        step();
        chk_out("flt_clear", 4'b0000, 1'b0, 1'b0);
        bus.req = 1'b1;
        step();
        chk_out("flt_reramp", 4'b0001, 1'b0, 1'b1);
`endif

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] en_s;
            if ($urandom_range(0, 5) == 0) bus.req = ~bus.req;
            if ($urandom_range(0, 39) == 0)
                bus.dly = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
            resetn = ($urandom_range(0, 499) != 0);
`ifdef DIGITAL_SEQ_FAULT_EN
            fault_v = ($urandom_range(0, 199) == 0);
`endif
            step();
            chk_out("rand", therm(m_level), !m_moving && !m_fault && m_level == N, m_moving);
            en_s = bus.en;
            chk("rand.therm", 32'(en_s & (en_s + 1'b1)), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
